mem_access_unit: RTL
====================

# mem_access_unit

Parametrised load/store access unit between the execute stage and the byte-enabled data memory. It turns an effective address, access size, direction and sign mode into word-addressed memory beats with per-byte write/read enables, and splits accesses that cross a word boundary into two beats. On loads it reassembles, aligns and sign- or zero-extends the returned data. Requests and responses use valid/ready handshakes.

## Interface
- DATA_W, 32: memory word width in bits; power of two, at least 16. BYTES = DATA_W/8, OFF_W = log2(BYTES).
- ADDR_W, 32: byte-address width.
- ALLOW_MISALIGN, 1: 1 = split boundary-crossing accesses into two beats; 0 = reject them with an error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword; N = 1<<size bytes.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_addr  out  ADDR_W-OFF_W  word address.
- mem_we  out  BYTES  byte write enables.
- mem_re  out  BYTES  byte read enables.
- mem_wdata  out  DATA_W  lane-aligned store data.
- mem_rdata  in  DATA_W  read data, valid the cycle after a read beat.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal size or rejected misalignment.

## Operation
- States: IDLE, ACC0, ACC1, CAP, RESP. req_ready = (state == IDLE). A request is accepted on a cycle with req_valid && req_ready, and all request fields are registered then.
- Lane math, little-endian: off = addr[OFF_W-1:0]. mask2 = ((1<<N)-1) << off, width 2*BYTES. wd2 = wdata[8N-1:0] << 8*off, width 2*DATA_W. Beat 0 uses the low halves. Beat 1 uses the high halves and exists only if mask2 high half != 0.
- Beat addresses: beat 0 at addr >> OFF_W; beat 1 at that address + 1, wrapping modulo 2^(ADDR_W-OFF_W).
- Errors: N > BYTES, or a two-beat access with ALLOW_MISALIGN = 0. The unit goes IDLE -> RESP with resp_err = 1, resp_rdata = 0, and issues no memory enable.
- Stores: ACC0 -> (ACC1 if two beats) -> RESP. In each beat state, mem_we = beat mask, mem_re = 0, and mem_wdata = beat data.
- Loads: ACC0 -> (ACC1 if two beats) -> CAP -> RESP. mem_re = beat mask and mem_we = 0.
  - Beat-0 data is captured in the cycle after ACC0 (ACC1 or CAP); beat-1 data is captured in CAP.
  - Result = ({b1, b0} >> 8*off), truncated to N bytes, then sign- or zero-extended to DATA_W.
- RESP holds resp_valid and its data stable until resp_ready, then returns to IDLE. No new request is accepted before that.
- Outside ACC0/ACC1: mem_we = mem_re = 0 and mem_wdata = 0; mem_addr holds its last value.

## Timing
- Reset values: mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, state = IDLE. req_ready reads 1, but no request is accepted while rst_n is low.
- Request accepted at cycle T. resp_valid first rises at:
  - T+1 for errors;
  - T+2 for one-beat stores, T+3 for two-beat stores;
  - T+3 for one-beat loads, T+4 for two-beat loads.
- Throughput is one request per response handshake. There is no pipelining.
- If rst_n asserts mid-operation, the access is aborted immediately: enables drop asynchronously and no response is produced for the aborted request.

## Structure
- Package mem_access_pkg holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - the state enum;
  - the function computing OFF_W from DATA_W.
- One combinational sub-module, lane_align, produces mask2, wd2 and the load extract/extend. It is instantiated once and verified standalone.

## Test plan
DATA_W = 32 throughout.
1. Store byte 0xAB to addr 0x13 → at T+1: mem_addr = 0x4, mem_we = 4'b1000, mem_wdata = 0xAB000000. At T+2: resp_valid = 1, resp_err = 0.
2. Signed load half from addr 0x22, with word 8 = 0x8001_1234 → at T+1: mem_re = 4'b1100. At T+3: resp_rdata = 0xFFFF8001. The same load unsigned returns 0x00008001.
3. Load word from 0x0D with ALLOW_MISALIGN = 1, word 3 = 0x44332211 and word 4 = 0x88776655 → beat 0: addr 3, re = 4'b1110. Beat 1: addr 4, re = 4'b0001. At T+4: resp_rdata = 0x55443322.
4. Same request with ALLOW_MISALIGN = 0 → no enables at any cycle. At T+1: resp_err = 1, resp_rdata = 0. Also: req_size = 3 → resp_err = 1.
5. Store word to 0xFFFFFFFE → beat 0 at addr 0x3FFFFFFF with we = 4'b1100; beat 1 wraps to addr 0 with we = 4'b0011. Separately: hold resp_ready low for 3 cycles → resp_valid and data stay stable, req_ready = 0.
6. Assert rst_n low during ACC1 of case 3 → enables are 0 immediately and no response follows. After release, req_ready = 1 and a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and lane-width helper shared by the load/store unit
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: byte-lane mask/data placement for stores and extract/extend for loads
// size/off: access size code and byte offset; wdata: right-justified store data
// rdata2: {beat1, beat0} returned words; sgn: sign-extend loads
// mask2/wd2: two-word byte mask and store data; rdata: aligned, extended load result
module lane_align import mem_access_pkg::*; #(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = off_w(DATA_W)
) (
    input  logic [1:0]          size,
    input  logic [OFF_W-1:0]    off,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [2*DATA_W-1:0] rdata2,
    input  logic                sgn,
    output logic [2*BYTES-1:0]  mask2,
    output logic [2*DATA_W-1:0] wd2,
    output logic [DATA_W-1:0]   rdata
);
    logic [3:0] nb;
    logic [6:0] nbits;
    logic [DATA_W-1:0] sh, keep, top;
    assign nb = 4'd1 << size;
    assign nbits = {nb, 3'b000};
    assign mask2 = ~({2*BYTES{1'b1}} << nb) << off;
    assign wd2 = ({{DATA_W{1'b0}}, wdata} & ~({2*DATA_W{1'b1}} << nbits)) << {off, 3'b000};
    assign sh = DATA_W'(rdata2 >> {off, 3'b000});
    assign keep = ~({DATA_W{1'b1}} << nbits);
    // one-hot on the most significant kept bit, i.e. the sign bit of the access
    assign top = keep ^ (keep >> 1);
    assign rdata = (sh & keep) | ((sgn && |(sh & top)) ? ~keep : '0);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit turning byte accesses into one or two word beats
// req_*: request handshake and fields; mem_*: word-addressed byte-enabled memory beats
// resp_*: response handshake with extended load data and error flag
module mem_access_unit import mem_access_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ALLOW_MISALIGN = 1,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = off_w(DATA_W),
    localparam int AW = ADDR_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [AW-1:0]     mem_addr,
    output logic [BYTES-1:0]  mem_we,
    output logic [BYTES-1:0]  mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    state_t state, state_n;
    logic r_write, r_signed, idle, acc, two, err;
    logic [1:0] r_size, cur_size;
    logic [OFF_W-1:0] r_off;
    logic [DATA_W-1:0] r_wdata, b0, ext;
    logic [2*BYTES-1:0] mask2;
    logic [2*DATA_W-1:0] wd2;
    assign idle = state == IDLE;
    assign acc = state == ACC0 || state == ACC1;
    // in IDLE the aligner looks at the incoming request to classify it; afterwards at the latched one
    assign cur_size = idle ? req_size : r_size;
    lane_align #(.DATA_W(DATA_W)) u_align (
        .size   (cur_size),
        .off    (idle ? req_addr[OFF_W-1:0] : r_off),
        .wdata  (r_wdata),
        .rdata2 (two ? {mem_rdata, b0} : {{DATA_W{1'b0}}, mem_rdata}),
        .sgn    (r_signed),
        .mask2  (mask2),
        .wd2    (wd2),
        .rdata  (ext)
    );
    assign two = |mask2[2*BYTES-1:BYTES];
    assign err = 32'(cur_size) > OFF_W || (two && ALLOW_MISALIGN == 0);
    assign req_ready = idle;
    assign resp_valid = state == RESP;
    assign mem_we = (acc && r_write) ? (state == ACC1 ? mask2[2*BYTES-1:BYTES] : mask2[BYTES-1:0]) : '0;
    assign mem_re = (acc && !r_write) ? (state == ACC1 ? mask2[2*BYTES-1:BYTES] : mask2[BYTES-1:0]) : '0;
    assign mem_wdata = (acc && r_write) ? (state == ACC1 ? wd2[2*DATA_W-1:DATA_W] : wd2[DATA_W-1:0]) : '0;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = err ? RESP : ACC0;
            ACC0:    state_n = two ? ACC1 : (r_write ? RESP : CAP);
            ACC1:    state_n = r_write ? RESP : CAP;
            CAP:     state_n = RESP;
            RESP:    if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r_write <= 1'b0;
            r_signed <= 1'b0;
            r_size <= '0;
            r_off <= '0;
            r_wdata <= '0;
            b0 <= '0;
            mem_addr <= '0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_n;
            if (idle && req_valid) begin
                r_write <= req_write;
                r_signed <= req_signed;
                r_size <= req_size;
                r_off <= req_addr[OFF_W-1:0];
                r_wdata <= req_wdata;
                resp_rdata <= '0;
                resp_err <= err;
            end
            if (idle && state_n == ACC0) mem_addr <= req_addr[ADDR_W-1:OFF_W];
            if (state_n == ACC1) mem_addr <= mem_addr + AW'(1);
            // memory returns beat-0 data while the unit sits in ACC1
            if (state == ACC1) b0 <= mem_rdata;
            if (state == CAP) resp_rdata <= ext;
        end
    end
endmodule
